// File: rtl/i2c_master_single_byte.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | i2c_master_single_byte: single-master, single-byte I2C read/write core  |
// | Rev 1.0 - initial release                                                |
// +-------------------------------------------------------------------------+
module i2c_master_single_byte #(
  parameter int CLK_RATIO = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic [6:0] i_Slave_Addr,
  input  logic       i_Wr_Start,
  input  logic       i_Rd_Start,
  input  logic [7:0] i_Wr_Byte,
  output logic       o_Busy,
  output logic [7:0] o_Rd_Byte,
  output logic       o_Error,
  inout  wire        io_scl,
  inout  wire        io_sda
);

  localparam int              c_QW   = 12;
  localparam logic [c_QW-1:0] c_QMAX = c_QW'(CLK_RATIO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA, S_RDATA, S_ACK2, S_STOP, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [c_QW-1:0] r_qcnt;
  logic [1:0]      r_qtr;
  logic [2:0]      r_bit;
  logic [7:0]      r_tx, r_rx, r_wbyte, r_rd_byte;
  logic            r_rw, r_nack, r_busy, r_error;
  logic            w_tick, w_bit_end, w_sample, w_start, w_in_xfer;
  logic            w_scl_low, w_sda_low, w_sda_in;

  assign w_tick    = (r_qcnt == c_QMAX);
  assign w_bit_end = w_tick && (r_qtr == 2'd3);
  assign w_sample  = w_tick && (r_qtr == 2'd2);
  assign w_start   = (r_state == S_IDLE) && i_Enable && (i_Wr_Start || i_Rd_Start);
  assign w_sda_in  = io_sda;

  assign io_scl    = w_scl_low ? 1'b0 : 1'bz;
  assign io_sda    = w_sda_low ? 1'b0 : 1'bz;
  assign o_Busy    = r_busy;
  assign o_Error   = r_error;
  assign o_Rd_Byte = r_rd_byte;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Line levels are decoded straight from state so an async reset releases them at once
  always_comb begin
    w_next    = r_state;
    w_scl_low = 1'b0;
    w_sda_low = 1'b0;
    w_in_xfer = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_START;
      S_START: begin
        w_in_xfer = 1'b1;
        w_sda_low = 1'b1;
        w_scl_low = r_qtr[1];
        if (w_bit_end) w_next = S_ADDR;
      end
      S_ADDR: begin
        w_in_xfer = 1'b1;
        w_scl_low = !r_qtr[1];
        w_sda_low = !r_tx[7];
        if (w_bit_end && r_bit == 3'd7) w_next = S_ACK1;
      end
      S_ACK1: begin
        w_in_xfer = 1'b1;
        w_scl_low = !r_qtr[1];
        if (w_bit_end) w_next = r_nack ? S_STOP : (r_rw ? S_RDATA : S_WDATA);
      end
      S_WDATA: begin
        w_in_xfer = 1'b1;
        w_scl_low = !r_qtr[1];
        w_sda_low = !r_tx[7];
        if (w_bit_end && r_bit == 3'd7) w_next = S_ACK2;
      end
      S_RDATA: begin
        w_in_xfer = 1'b1;
        w_scl_low = !r_qtr[1];
        if (w_bit_end && r_bit == 3'd7) w_next = S_ACK2;
      end
      S_ACK2: begin
        w_in_xfer = 1'b1;
        w_scl_low = !r_qtr[1];
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        w_scl_low = !r_qtr[1];
        w_sda_low = 1'b1;
        if (w_bit_end) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_in_xfer && w_bit_end && !i_Enable) w_next = S_STOP;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_qcnt    <= '0;
      r_qtr     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_wbyte   <= '0;
      r_rd_byte <= '0;
      r_rw      <= 1'b0;
      r_nack    <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_qtr  <= '0;
      end else begin
        r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
        if (w_tick) r_qtr <= r_qtr + 1'b1;
      end

      if (w_next != r_state) r_bit <= '0;
      else if (w_bit_end)    r_bit <= r_bit + 1'b1;

      if (w_start) begin
        r_tx    <= {i_Slave_Addr, !i_Wr_Start};
        r_rw    <= !i_Wr_Start;
        r_wbyte <= i_Wr_Byte;
        r_busy  <= 1'b1;
        r_error <= 1'b0;
      end

      if (w_bit_end && (r_state == S_ADDR || r_state == S_WDATA)) r_tx <= {r_tx[6:0], 1'b1};
      if (w_bit_end && r_state == S_ACK1) r_tx <= r_wbyte;

      // Anything other than a clean low (high, Z, X) is taken as NACK
      if (w_sample) begin
        if (w_sda_in == 1'b0) r_nack <= 1'b0;
        else                  r_nack <= 1'b1;
        if (r_state == S_RDATA) r_rx <= {r_rx[6:0], w_sda_in};
      end

      if (w_bit_end && r_state == S_RDATA && r_bit == 3'd7) r_rd_byte <= r_rx;
      if (w_bit_end && r_nack && (r_state == S_ACK1 || (r_state == S_ACK2 && !r_rw)))
        r_error <= 1'b1;
      if (r_state == S_DONE) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_single_byte.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_i2c_master_single_byte: directed bench with a simple I2C slave model |
// | Rev 1.0 - initial release                                                |
// +-------------------------------------------------------------------------+
module tb_i2c_master_single_byte;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Enable = 1'b1;
  logic [6:0] i_Slave_Addr = 7'h51;
  logic       i_Wr_Start = 1'b0;
  logic       i_Rd_Start = 1'b0;
  logic [7:0] i_Wr_Byte = 8'hAC;
  logic       o_Busy;
  logic [7:0] o_Rd_Byte;
  logic       o_Error;
  wire        io_scl;
  wire        io_sda;

  pullup (io_scl);
  pullup (io_sda);

  i2c_master_single_byte #(.CLK_RATIO(25)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Enable(i_Enable),
    .i_Slave_Addr(i_Slave_Addr), .i_Wr_Start(i_Wr_Start), .i_Rd_Start(i_Rd_Start),
    .i_Wr_Byte(i_Wr_Byte), .o_Busy(o_Busy), .o_Rd_Byte(o_Rd_Byte), .o_Error(o_Error),
    .io_scl(io_scl), .io_sda(io_sda)
  );

  always #5 i_Clk = ~i_Clk;

  // Slave model: frame bits 0..7 address+R/W, 8 ACK1, 9..16 data, 17 ACK2
  logic       slv_present = 1'b1;
  logic [7:0] slv_rd_data = 8'h5A;
  logic       slv_low = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       m_scl, m_sda;
  int         bitn = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] addr_seen = 8'h00, data_seen = 8'h00;
  logic       ack1_seen = 1'b1, ack2_seen = 1'b1;

  assign io_sda = slv_low ? 1'b0 : 1'bz;
  assign m_scl  = (io_scl === 1'b0) ? 1'b0 : 1'b1;
  assign m_sda  = (io_sda === 1'b0) ? 1'b0 : 1'b1;

  always @(posedge i_Clk) begin
    p_scl <= m_scl;
    p_sda <= m_sda;
    if (p_scl && m_scl && p_sda && !m_sda) begin
      bitn      <= 0;
      start_cnt <= start_cnt + 1;
    end
    if (p_scl && m_scl && !p_sda && m_sda) stop_cnt <= stop_cnt + 1;
    if (!p_scl && m_scl) begin
      if (bitn < 8) addr_seen <= {addr_seen[6:0], m_sda};
      if (bitn == 8) ack1_seen <= m_sda;
      if (bitn >= 9 && bitn <= 16) data_seen <= {data_seen[6:0], m_sda};
      if (bitn == 17) ack2_seen <= m_sda;
      bitn <= bitn + 1;
    end
    if (p_scl && !m_scl) begin
      slv_low <= slv_present &&
                 ((bitn == 8) ||
                  (addr_seen[0] && bitn >= 9 && bitn <= 16 && !slv_rd_data[16 - bitn]) ||
                  (!addr_seen[0] && bitn == 17));
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses the start inputs, then counts cycles with o_Busy high; drop_at>0 lowers i_Enable mid-way
  task automatic xfer(input logic wr, input logic rd, input int drop_at,
                      output int cyc, output logic busy0, output logic err0);
    @(negedge i_Clk);
    i_Wr_Start = wr;
    i_Rd_Start = rd;
    @(posedge i_Clk);
    #1;
    i_Wr_Start = 1'b0;
    i_Rd_Start = 1'b0;
    busy0 = o_Busy;
    err0  = o_Error;
    cyc   = 0;
    while (o_Busy === 1'b1 && cyc < 5000) begin
      cyc++;
      if (drop_at > 0 && cyc == drop_at) i_Enable = 1'b0;
      @(posedge i_Clk);
      #1;
    end
    i_Enable = 1'b1;
    repeat (20) @(posedge i_Clk);
    #1;
  endtask

  int   cyc, s_stop, s_start;
  logic b0, e0;

  initial begin
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk) i_Rst_n = 1'b1;
    repeat (5) @(posedge i_Clk);
    #1;
    check("reset_busy", o_Busy, 1'b0);
    check("reset_error", o_Error, 1'b0);
    check("reset_rdbyte", o_Rd_Byte, 8'h00);
    check("reset_scl", m_scl, 1'b1);
    check("reset_sda", m_sda, 1'b1);

    // Write 0x51/0xAC, slave ACKs: START+8+ACK+8+ACK+STOP = 20 bits of 100 clocks, +1 DONE
    s_stop = stop_cnt;
    xfer(1'b1, 1'b0, 0, cyc, b0, e0);
    check("wr_busy_next", b0, 1'b1);
    check("wr_busy_cycles", cyc, 2001);
    check("wr_addr_byte", addr_seen, 8'hA2);
    check("wr_ack1", ack1_seen, 1'b0);
    check("wr_data_byte", data_seen, 8'hAC);
    check("wr_ack2", ack2_seen, 1'b0);
    check("wr_error", o_Error, 1'b0);
    check("wr_stop", stop_cnt - s_stop, 1);
    check("wr_lines_idle", {m_scl, m_sda}, 2'b11);

    // No slave: NACK at ACK1, STOP right after address = 11 bits +1
    slv_present = 1'b0;
    s_stop = stop_cnt;
    xfer(1'b1, 1'b0, 0, cyc, b0, e0);
    check("nack_busy_cycles", cyc, 1101);
    check("nack_ack1", ack1_seen, 1'b1);
    check("nack_error", o_Error, 1'b1);
    check("nack_stop", stop_cnt - s_stop, 1);
    slv_present = 1'b1;

    // Read returning 0x5A; error from the previous NACK is cleared on accept
    xfer(1'b0, 1'b1, 0, cyc, b0, e0);
    check("rd_err_cleared", e0, 1'b0);
    check("rd_busy_cycles", cyc, 2001);
    check("rd_addr_byte", addr_seen, 8'hA3);
    check("rd_bus_data", data_seen, 8'h5A);
    check("rd_master_nack", ack2_seen, 1'b1);
    check("rd_byte", o_Rd_Byte, 8'h5A);
    check("rd_error", o_Error, 1'b0);

    // Start pulse while busy is ignored
    s_start = start_cnt;
    @(negedge i_Clk) i_Wr_Start = 1'b1;
    @(negedge i_Clk) i_Wr_Start = 1'b0;
    repeat (500) @(posedge i_Clk);
    @(negedge i_Clk) i_Rd_Start = 1'b1;
    @(negedge i_Clk) i_Rd_Start = 1'b0;
    cyc = 0;
    while (o_Busy === 1'b1 && cyc < 5000) begin
      cyc++;
      @(posedge i_Clk);
      #1;
    end
    check("busy_wait_bound", cyc < 5000, 1'b1);
    repeat (20) @(posedge i_Clk);
    check("busy_start_ignored", start_cnt - s_start, 1);
    check("busy_addr_write", addr_seen, 8'hA2);
    check("busy_rdbyte_hold", o_Rd_Byte, 8'h5A);

    // Start with i_Enable low is ignored
    i_Enable = 1'b0;
    s_start = start_cnt;
    @(negedge i_Clk) i_Wr_Start = 1'b1;
    @(negedge i_Clk) i_Wr_Start = 1'b0;
    repeat (50) @(posedge i_Clk);
    #1;
    check("dis_busy", o_Busy, 1'b0);
    check("dis_no_traffic", start_cnt - s_start, 0);
    i_Enable = 1'b1;

    // Both starts together: write wins
    i_Wr_Byte = 8'h3C;
    xfer(1'b1, 1'b1, 0, cyc, b0, e0);
    check("both_cycles", cyc, 2001);
    check("both_addr_write", addr_seen, 8'hA2);
    check("both_data", data_seen, 8'h3C);
    check("both_rdbyte_hold", o_Rd_Byte, 8'h5A);

    // Enable dropped during address bit 1: bit finishes at cycle 300, STOP, DONE -> 401
    s_stop = stop_cnt;
    xfer(1'b1, 1'b0, 250, cyc, b0, e0);
    check("en_drop_cycles", cyc, 401);
    check("en_drop_stop", stop_cnt - s_stop, 1);

    // Async reset mid-address: outputs and lines respond before the next edge
    @(negedge i_Clk) i_Rd_Start = 1'b1;
    @(negedge i_Clk) i_Rd_Start = 1'b0;
    repeat (300) @(posedge i_Clk);
    #3 i_Rst_n = 1'b0;
    #1;
    check("rst_mid_busy", o_Busy, 1'b0);
    check("rst_mid_rdbyte", o_Rd_Byte, 8'h00);
    check("rst_mid_lines", {m_scl, m_sda}, 2'b11);
    @(negedge i_Clk) i_Rst_n = 1'b1;
    repeat (10) @(posedge i_Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
